// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the pipelined on-chip RAM.
// Imported by the RAM top level and its array.
package onchip_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 2;

endpackage

// File: rtl/onchip_ram_pl_if.sv
// Slave bus of the pipelined on-chip RAM, including clock-enable/freeze controls.
// Clock and reset are not part of this bus.
interface onchip_ram_pl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   logic                  reset_req;
   logic                  clken;
   logic                  chipselect;
   logic                  read;
   logic                  write;
   logic [ADDR_W-1:0]     address;
   logic [DATA_W/8-1:0]   byteenable;
   logic [DATA_W-1:0]     writedata;
   logic [DATA_W-1:0]     readdata;
   logic                  readdatavalid;
   logic                  waitrequest;
   logic                  init_done;

   modport slave (
      input  reset_req, clken, chipselect, read, write, address, byteenable, writedata,
      output readdata, readdatavalid, waitrequest, init_done
   );

   modport master (
      output reset_req, clken, chipselect, read, write, address, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest, init_done
   );
endinterface

// File: rtl/onchip_ram_array.sv
// DEPTH x DATA_W single-port storage with byte-lane writes and a registered,
// clock-enabled synchronous read port.
module onchip_ram_array #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ce,
   input  logic                we,
   input  logic                re,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);
   localparam int LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: storage has no reset so it maps onto block RAM; zeroing is done by the CLEAR walk.
   always_ff @(posedge clk) begin
      if (ce && we) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             rdata <= '0;
      else if (ce && re)   rdata <= mem[addr];
   end
endmodule

// File: rtl/onchip_ram_pl.sv
// Pipelined on-chip RAM: post-reset zero-fill FSM, transfer acceptance,
// read-valid pipeline and optional second output register stage.
module onchip_ram_pl
   import onchip_ram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 2,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic            clk,
   input  logic            reset,
   onchip_ram_pl_if.slave  bus
);
   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
   logic                clocken;
   logic                in_clear;
   logic                accept;
   logic                acc_rd;
   logic                acc_wr;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_addr;
   logic [DATA_W/8-1:0] mem_be;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                vld1;

   assign clocken          = bus.clken & ~bus.reset_req;
   assign in_clear         = (state == ST_CLEAR);
   assign bus.waitrequest  = in_clear | ~clocken;
   assign accept           = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
   // A simultaneous read+write is a write only and produces no response.
   assign acc_wr           = accept & bus.write;
   assign acc_rd           = accept & bus.read & ~bus.write;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt       <= '0;
         bus.init_done <= (CLEAR_ON_RESET == 0);
      end else begin
         state         <= state_nxt;
         clr_cnt       <= clr_cnt_nxt;
         bus.init_done <= (state_nxt == ST_READY);
      end
   end

   // NOTE: defaults first so every path assigns every output and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      if (clocken && in_clear) begin
         clr_cnt_nxt = clr_cnt + ADDR_W'(1);
         if (&clr_cnt) state_nxt = ST_READY;
      end
   end

   assign mem_we    = in_clear | acc_wr;
   assign mem_addr  = in_clear ? clr_cnt : bus.address;
   assign mem_be    = in_clear ? '1      : bus.byteenable;
   assign mem_wdata = in_clear ? '0      : bus.writedata;

   onchip_ram_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst   (reset),
      .ce    (clocken),
      .we    (mem_we),
      .re    (acc_rd),
      .addr  (mem_addr),
      .be    (mem_be),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        vld1 <= 1'b0;
      else if (clocken) vld1 <= acc_rd;
   end

   // Valid is gated by clocken so a stalled response pulses only once it can advance.
   if (READ_LATENCY == READ_LAT_MAX) begin : g_lat2
      logic              vld2;
      logic [DATA_W-1:0] rd_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            vld2 <= 1'b0;
            rd_q <= '0;
         end else if (clocken) begin
            vld2 <= vld1;
            if (vld1) rd_q <= mem_rdata;
         end
      end

      assign bus.readdata      = rd_q;
      assign bus.readdatavalid = vld2 & clocken;
   end else begin : g_lat1
      assign bus.readdata      = mem_rdata;
      assign bus.readdatavalid = vld1 & clocken;
   end
endmodule

// File: tb/tb_onchip_ram_pl.sv
// Bench for onchip_ram_pl: READ_LATENCY=1 and =2 instances share one stimulus
// stream and are scored every cycle against a transaction-level model.
module tb_onchip_ram_pl;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;
   localparam int LANES  = 4;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                edges;
   } rd_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   onchip_ram_pl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
   onchip_ram_pl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

   assign bus2.reset_req  = bus1.reset_req;
   assign bus2.clken      = bus1.clken;
   assign bus2.chipselect = bus1.chipselect;
   assign bus2.read       = bus1.read;
   assign bus2.write      = bus1.write;
   assign bus2.address    = bus1.address;
   assign bus2.byteenable = bus1.byteenable;
   assign bus2.writedata  = bus1.writedata;

   onchip_ram_pl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
   ) u_dut_l1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   onchip_ram_pl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
   ) u_dut_l2 (
      .clk(clk), .reset(reset), .bus(bus2)
   );

   // Reference model
   logic [DATA_W-1:0] mem [DEPTH];
   rd_t               pend[$];
   bit                m_ready;
   int                m_clr;
   logic [DATA_W-1:0] hold [2];

   // Observations
   int                cycle;
   int                last_v_cycle [2];
   logic [DATA_W-1:0] last_v_data [2];
   int                v_count [2];
   logic [DATA_W-1:0] seen2[$];
   int                seen2_cyc[$];

   int n_assert = 0;
   int n_fail   = 0;

   // One bus cycle: score outputs against the model, advance the model, wait for the next negedge.
   task automatic tick();
      bit                ce;
      bit                exp_v;
      logic [DATA_W-1:0] exp_d;
      logic [1:0]        o_v, o_w, o_i;
      logic [DATA_W-1:0] o_d [2];
      #1;
      ce     = bus1.clken && !bus1.reset_req;
      o_v    = {bus2.readdatavalid, bus1.readdatavalid};
      o_w    = {bus2.waitrequest,   bus1.waitrequest};
      o_i    = {bus2.init_done,     bus1.init_done};
      o_d[0] = bus1.readdata;
      o_d[1] = bus2.readdata;
      for (int d = 0; d < 2; d++) begin
         exp_v = 1'b0;
         exp_d = hold[d];
         foreach (pend[i]) if (ce && pend[i].edges == d + 1) begin
            exp_v = 1'b1;
            exp_d = pend[i].data;
         end
         n_assert++;
         if (o_w[d] !== (!m_ready || !ce)) begin
            n_fail++;
            $display("FAIL waitrequest lat%0d cycle %0d: got %b expected %b", d + 1, cycle, o_w[d], !m_ready || !ce);
         end
         n_assert++;
         if (o_i[d] !== m_ready) begin
            n_fail++;
            $display("FAIL init_done lat%0d cycle %0d: got %b expected %b", d + 1, cycle, o_i[d], m_ready);
         end
         n_assert++;
         if (o_v[d] !== exp_v) begin
            n_fail++;
            $display("FAIL readdatavalid lat%0d cycle %0d: got %b expected %b", d + 1, cycle, o_v[d], exp_v);
         end
         if (exp_v || ce) begin
            n_assert++;
            if (o_d[d] !== exp_d) begin
               n_fail++;
               $display("FAIL readdata lat%0d cycle %0d: got %h expected %h", d + 1, cycle, o_d[d], exp_d);
            end
         end
         if (o_v[d] === 1'b1) begin
            last_v_cycle[d] = cycle;
            last_v_data[d]  = o_d[d];
            v_count[d]++;
            if (d == 1) begin
               seen2.push_back(o_d[d]);
               seen2_cyc.push_back(cycle);
            end
         end
         if (exp_v) hold[d] = exp_d;
      end
      if (ce) begin
         foreach (pend[i]) pend[i].edges++;
         while (pend.size() > 0 && pend[0].edges > 2) void'(pend.pop_front());
         if (!m_ready) begin
            mem[m_clr] = '0;
            m_clr++;
            if (m_clr == DEPTH) m_ready = 1'b1;
         end else if (bus1.chipselect && (bus1.read || bus1.write)) begin
            if (bus1.write) begin
               for (int b = 0; b < LANES; b++)
                  if (bus1.byteenable[b]) mem[bus1.address][8*b +: 8] = bus1.writedata[8*b +: 8];
            end else begin
               pend.push_back('{data: mem[bus1.address], edges: 1});
            end
         end
      end
      cycle++;
      @(negedge clk);
   endtask

   task automatic drive(input logic cs, input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [LANES-1:0] be, input logic [DATA_W-1:0] wd);
      bus1.chipselect = cs;
      bus1.read       = rd;
      bus1.write      = wr;
      bus1.address    = a;
      bus1.byteenable = be;
      bus1.writedata  = wd;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      m_ready = 1'b0;
      m_clr   = 0;
      pend.delete();
      hold[0] = '0;
      hold[1] = '0;
      n_assert++;
      if (bus1.readdata !== '0 || bus2.readdata !== '0) begin
         n_fail++;
         $display("FAIL reset_readdata: got %h/%h expected 0", bus1.readdata, bus2.readdata);
      end
      n_assert++;
      if (bus1.readdatavalid !== 1'b0 || bus2.readdatavalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid: got %b/%b expected 0", bus1.readdatavalid, bus2.readdatavalid);
      end
      n_assert++;
      if (bus1.init_done !== 1'b0 || bus2.init_done !== 1'b0 || bus1.waitrequest !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_status: got init %b/%b wait %b expected init 0 wait 1",
                  bus1.init_done, bus2.init_done, bus1.waitrequest);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int vc0, vc1;
      do_reset();
      idle(3);
      n_assert++;
      if (bus1.init_done !== 1'b0 || bus1.waitrequest !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_len_early: got init %b wait %b expected init 0 wait 1", bus1.init_done, bus1.waitrequest);
      end
      idle(1);
      n_assert++;
      if (bus1.init_done !== 1'b1 || bus2.init_done !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_len_done: got %b/%b expected 1", bus1.init_done, bus2.init_done);
      end
      vc0 = v_count[0];
      vc1 = v_count[1];
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, 1'b0, ADDR_W'(a), '0, '0);
      idle(3);
      n_assert++;
      if (v_count[0] - vc0 != 4 || v_count[1] - vc1 != 4 || last_v_data[0] !== '0 || last_v_data[1] !== '0) begin
         n_fail++;
         $display("FAIL cleared_reads: got %0d/%0d responses last %h/%h expected 4/4 zero",
                  v_count[0] - vc0, v_count[1] - vc1, last_v_data[0], last_v_data[1]);
      end
   endtask

   task automatic test_byte_lanes();
      int c;
      drive(1'b1, 1'b0, 1'b1, 2'd1, 4'hF, 32'hDEADBEEF);
      drive(1'b1, 1'b0, 1'b1, 2'd1, 4'b0001, 32'h000000AA);
      c = cycle;
      drive(1'b1, 1'b1, 1'b0, 2'd1, '0, '0);
      idle(3);
      n_assert++;
      if (last_v_cycle[0] != c + 1 || last_v_data[0] !== 32'hDEADBEAA) begin
         n_fail++;
         $display("FAIL byte_lanes_lat1: got %h at +%0d expected DEADBEAA at +1", last_v_data[0], last_v_cycle[0] - c);
      end
      n_assert++;
      if (last_v_cycle[1] != c + 2 || last_v_data[1] !== 32'hDEADBEAA) begin
         n_fail++;
         $display("FAIL byte_lanes_lat2: got %h at +%0d expected DEADBEAA at +2", last_v_data[1], last_v_cycle[1] - c);
      end
   endtask

   task automatic test_read_after_write();
      drive(1'b1, 1'b0, 1'b1, 2'd2, 4'hF, 32'h12345678);
      drive(1'b1, 1'b1, 1'b0, 2'd2, '0, '0);
      idle(3);
      n_assert++;
      if (last_v_data[0] !== 32'h12345678 || last_v_data[1] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL read_after_write: got %h/%h expected 12345678", last_v_data[0], last_v_data[1]);
      end
   endtask

   task automatic test_back_to_back();
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b0, 1'b1, ADDR_W'(a), 4'hF, 32'hC0DE0000 + a);
      seen2.delete();
      seen2_cyc.delete();
      for (int a = 0; a < DEPTH; a++) drive(1'b1, 1'b1, 1'b0, ADDR_W'(a), '0, '0);
      idle(3);
      n_assert++;
      if (seen2.size() != DEPTH) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d expected %0d", seen2.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            n_assert++;
            if (seen2[i] !== 32'hC0DE0000 + i || seen2_cyc[i] != seen2_cyc[0] + i) begin
               n_fail++;
               $display("FAIL b2b_item%0d: got %h at +%0d expected %h at +%0d",
                        i, seen2[i], seen2_cyc[i] - seen2_cyc[0], 32'hC0DE0000 + i, i);
            end
         end
      end
   endtask

   task automatic test_freeze();
      int c, vc0;
      drive(1'b1, 1'b0, 1'b1, 2'd3, 4'hF, 32'h5A5AA5A5);
      c   = cycle;
      vc0 = v_count[0];
      drive(1'b1, 1'b1, 1'b0, 2'd3, '0, '0);
      bus1.reset_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_assert++;
         if (bus1.waitrequest !== 1'b1 || bus1.readdatavalid !== 1'b0 || bus2.readdatavalid !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_%0d: got wait %b valid %b/%b expected wait 1 valid 0",
                     i, bus1.waitrequest, bus1.readdatavalid, bus2.readdatavalid);
         end
         idle(1);
      end
      bus1.reset_req = 1'b0;
      idle(3);
      n_assert++;
      if (v_count[0] - vc0 != 1 || last_v_cycle[0] != c + 4 || last_v_data[0] !== 32'h5A5AA5A5) begin
         n_fail++;
         $display("FAIL freeze_release_lat1: got %0d pulses %h at +%0d expected 1 pulse 5A5AA5A5 at +4",
                  v_count[0] - vc0, last_v_data[0], last_v_cycle[0] - c);
      end
      n_assert++;
      if (last_v_cycle[1] != c + 5 || last_v_data[1] !== 32'h5A5AA5A5) begin
         n_fail++;
         $display("FAIL freeze_release_lat2: got %h at +%0d expected 5A5AA5A5 at +5", last_v_data[1], last_v_cycle[1] - c);
      end
   endtask

   task automatic test_reset_mid_clear();
      int vc0, vc1;
      drive(1'b1, 1'b0, 1'b1, 2'd0, 4'hF, 32'hFFFF0000);
      vc0 = v_count[0];
      vc1 = v_count[1];
      drive(1'b1, 1'b1, 1'b0, 2'd0, '0, '0);
      do_reset();
      idle(2);
      do_reset();
      idle(3);
      n_assert++;
      if (bus1.init_done !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_clear_early: got init %b expected 0", bus1.init_done);
      end
      idle(1);
      n_assert++;
      if (bus1.init_done !== 1'b1 || v_count[0] != vc0 || v_count[1] != vc1) begin
         n_fail++;
         $display("FAIL restart_clear_done: got init %b stale pulses %0d/%0d expected init 1 none",
                  bus1.init_done, v_count[0] - vc0, v_count[1] - vc1);
      end
      vc0 = v_count[0];
      drive(1'b1, 1'b1, 1'b1, 2'd2, 4'hF, 32'h0BADF00D);
      idle(3);
      n_assert++;
      if (v_count[0] != vc0) begin
         n_fail++;
         $display("FAIL rd_wr_same_cycle: got %0d pulses expected 0", v_count[0] - vc0);
      end
      drive(1'b1, 1'b1, 1'b0, 2'd2, '0, '0);
      idle(3);
      n_assert++;
      if (last_v_data[0] !== 32'h0BADF00D || last_v_data[1] !== 32'h0BADF00D) begin
         n_fail++;
         $display("FAIL rd_wr_write_done: got %h/%h expected 0BADF00D", last_v_data[0], last_v_data[1]);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         bus1.clken     = ($urandom_range(0, 7) != 0);
         bus1.reset_req = ($urandom_range(0, 11) == 0);
         drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), ADDR_W'($urandom),
               LANES'($urandom), DATA_W'($urandom));
      end
      bus1.clken     = 1'b1;
      bus1.reset_req = 1'b0;
      idle(3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      cycle           = 0;
      v_count[0]      = 0;
      v_count[1]      = 0;
      last_v_cycle[0] = -1;
      last_v_cycle[1] = -1;
      bus1.clken      = 1'b1;
      bus1.reset_req  = 1'b0;
      bus1.chipselect = 1'b0;
      bus1.read       = 1'b0;
      bus1.write      = 1'b0;
      bus1.address    = '0;
      bus1.byteenable = '0;
      bus1.writedata  = '0;
      test_reset();
      test_byte_lanes();
      test_read_after_write();
      test_back_to_back();
      test_freeze();
      test_reset_mid_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/onchip_ram_pl.md
ONCHIP_RAM_PL -- requirements
Module: onchip_ram_pl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; multiple of 8, 8..128.
REQ-002 SHALL have parameter ADDR_W, default 2, word address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LATENCY, default 1, read pipeline depth; legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero-fill whole array after reset.
REQ-005 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port reset_req  input  1  high = freeze (suppress clock enable).
REQ-008 SHALL have port clken  input  1  clock enable.
REQ-009 SHALL have port chipselect  input  1  slave select.
REQ-010 SHALL have port read  input  1  read request.
REQ-011 SHALL have port write  input  1  write request.
REQ-012 SHALL have port address  input  ADDR_W  word address.
REQ-013 SHALL have port byteenable  input  DATA_W/8  per-lane write enable.
REQ-014 SHALL have port writedata  input  DATA_W  write data.
REQ-015 SHALL have port readdata  output  DATA_W  read data, registered.
REQ-016 SHALL have port readdatavalid  output  1  one-cycle pulse per returned read.
REQ-017 SHALL have port waitrequest  output  1  high = request not accepted this cycle.
REQ-018 SHALL have port init_done  output  1  high once array is usable.

Function
REQ-019 SHALL define clocken = clken & ~reset_req; while clocken=0, no state, counter, pipeline stage or array content changes.
REQ-020 SHALL use state machine CLEAR/READY; after reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-021 In CLEAR SHALL write all-zero (all lanes) to address clr_cnt each clocken cycle, clr_cnt counting 0..DEPTH-1, then enter READY; clear takes exactly DEPTH clocken cycles, no wrap.
REQ-022 SHALL drive waitrequest = (state==CLEAR) | ~clocken, combinationally.
REQ-023 SHALL drive init_done = (state==READY), registered.
REQ-024 SHALL accept a transfer when chipselect & (read|write) & ~waitrequest.
REQ-025 Accepted write SHALL update only lanes whose byteenable bit is 1 at the clock edge ending the accept cycle.
REQ-026 read and write both high SHALL be treated as write only; no readdatavalid generated.
REQ-027 Accepted read SHALL assert readdatavalid for exactly one cycle, READ_LATENCY clocken cycles after acceptance, with readdata valid in that cycle.
REQ-028 Back-to-back reads SHALL be accepted every cycle, returning data in issue order with no bubbles.
REQ-029 A read SHALL return array contents including every write accepted in any earlier cycle (new-data semantics for read-after-write at same address).
REQ-030 readdata SHALL hold its last value while readdatavalid=0.
REQ-031 Reads in flight when clocken falls SHALL stall in place and complete once clocken returns.
REQ-032 Array contents SHALL be unaffected by reset except via CLEAR.

Reset
REQ-033 On reset: readdata=0, readdatavalid=0, read pipeline valid bits=0, clr_cnt=0, state per REQ-020, init_done=0 if CLEAR_ON_RESET else 1.
REQ-034 Reset asserted mid-CLEAR SHALL restart clearing from address 0 after release.
REQ-035 Reset asserted with reads in flight SHALL discard them; no readdatavalid after release for those reads.

Structure
REQ-036 SHALL place state enum (CLEAR, READY) and legal-READ_LATENCY constants in shared package onchip_ram_pkg.
REQ-037 SHALL instantiate one sub-module onchip_ram_array: DEPTH x DATA_W, byte-lane write enables, synchronous read, clock-enabled.
REQ-038 Top SHALL contain FSM, clear counter, acceptance logic and latency-2 output register stage.

Verification
REQ-039 Reset release, CLEAR_ON_RESET=1, DEPTH=4, clken=1 -> waitrequest=1 for 4 cycles, init_done=1 in cycle 5, read of all 4 words returns 0.
REQ-040 Write 0xDEADBEEF addr 1, then write 0x000000AA byteenable 4'b0001 addr 1, read addr 1 -> readdata 0xDEADBEAA with readdatavalid exactly READ_LATENCY cycles after read accept.
REQ-041 READ_LATENCY=2, reads addr 0,1,2,3 on consecutive cycles -> 4 consecutive readdatavalid pulses, data in address order.
REQ-042 Write 0x12345678 addr 2 cycle N, read addr 2 cycle N+1 -> readdata 0x12345678.
REQ-043 reset_req high 3 cycles with a read in flight -> waitrequest=1, no readdatavalid during freeze, single readdatavalid after release with correct data.
REQ-044 Reset pulsed after 2 CLEAR cycles -> clear restarts at address 0, init_done after 4 further cycles; read+write same cycle -> write performed, no readdatavalid.
